// File: rtl/nasti_pkg.sv
// Shared NASTI-lite write-slave types: response codes, B-queue entry and FSM states.
package nasti_pkg;

  localparam int unsigned MAX_ID_WIDTH   = 16;
  localparam int unsigned MAX_USER_WIDTH = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Sized for the widest supported id/user; narrower configurations zero-extend.
  typedef struct packed {
    logic [MAX_ID_WIDTH-1:0]   id;
    logic [1:0]                resp;
    logic [MAX_USER_WIDTH-1:0] user;
  } b_entry_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } wr_state_e;

endpackage

// File: rtl/nasti_lite_b_fifo.sv
// Write-response queue: in-order FIFO, full/empty from the registered count.
module nasti_lite_b_fifo
  import nasti_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type entry_t = b_entry_t
) (
  input  logic   clk,
  input  logic   rstn,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   empty,
  output logic   full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // No pop bypass: a full queue refuses a push even when it pops that cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/nasti_lite_wr_slave.sv
// NASTI-lite write slave: holds one AW and one W beat, range/strobe checks them,
// issues a single-beat memory write and queues the B response.
module nasti_lite_wr_slave
  import nasti_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned ADDR_SPAN  = 128,
  parameter int unsigned B_DEPTH    = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [ID_WIDTH-1:0]     lite_aw_id,
  input  logic [ADDR_WIDTH-1:0]   lite_aw_addr,
  input  logic [USER_WIDTH-1:0]   lite_aw_user,
  input  logic [2:0]              lite_aw_prot,
  input  logic [3:0]              lite_aw_qos,
  input  logic [3:0]              lite_aw_region,
  input  logic                    lite_aw_valid,
  output logic                    lite_aw_ready,
  input  logic [DATA_WIDTH-1:0]   lite_w_data,
  input  logic [DATA_WIDTH/8-1:0] lite_w_strb,
  input  logic [USER_WIDTH-1:0]   lite_w_user,
  input  logic                    lite_w_valid,
  output logic                    lite_w_ready,
  output logic [ID_WIDTH-1:0]     lite_b_id,
  output logic [1:0]              lite_b_resp,
  output logic [USER_WIDTH-1:0]   lite_b_user,
  output logic                    lite_b_valid,
  input  logic                    lite_b_ready,
  output logic                    mem_req,
  input  logic                    mem_gnt,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb
);

  localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned OFFSET_BITS = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(ADDR_SPAN);

  wr_state_e              state;
  wr_state_e              state_d;
  logic                   rst_done;
  logic                   aw_held;
  logic                   w_held;
  logic [ID_WIDTH-1:0]    aw_id;
  logic [ADDR_WIDTH-1:0]  aw_addr;
  logic [USER_WIDTH-1:0]  aw_user;
  logic [DATA_WIDTH-1:0]  w_data;
  logic [STRB_WIDTH-1:0]  w_strb;
  logic                   aw_hs;
  logic                   w_hs;
  logic                   in_range;
  logic                   done;
  logic                   b_push;
  b_entry_t               b_push_data;
  b_entry_t               b_head;
  logic                   b_empty;
  logic                   b_full;
  logic                   unused_ok;

  // rst_done keeps both readies low for the cycles reset is sampled.
  assign lite_aw_ready = rst_done && !aw_held;
  assign lite_w_ready  = rst_done && !w_held;
  assign aw_hs         = lite_aw_valid && lite_aw_ready;
  assign w_hs          = lite_w_valid && lite_w_ready;
  assign in_range      = ({1'b0, aw_addr} < SPAN);

  assign mem_req   = (state == ST_ISSUE);
  assign mem_addr  = {aw_addr[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'(0)};
  assign mem_wdata = w_data;
  assign mem_wstrb = w_strb;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      rst_done <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
    end else begin
      state    <= state_d;
      rst_done <= 1'b1;
      if (aw_hs)     aw_held <= 1'b1;
      else if (done) aw_held <= 1'b0;
      if (w_hs)      w_held <= 1'b1;
      else if (done) w_held <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) begin
      aw_id   <= lite_aw_id;
      aw_addr <= lite_aw_addr;
      aw_user <= lite_aw_user;
    end
    if (w_hs) begin
      w_data <= lite_w_data;
      w_strb <= lite_w_strb;
    end
  end

  // Error and empty-strobe writes complete from IDLE without touching memory.
  always_comb begin
    state_d          = state;
    done             = 1'b0;
    b_push           = 1'b0;
    b_push_data      = '0;
    b_push_data.id   = MAX_ID_WIDTH'(aw_id);
    b_push_data.user = MAX_USER_WIDTH'(aw_user);
    b_push_data.resp = RESP_OKAY;
    case (state)
      ST_IDLE: begin
        if (aw_held && w_held && !b_full) begin
          if (!in_range) begin
            b_push           = 1'b1;
            b_push_data.resp = RESP_SLVERR;
            done             = 1'b1;
          end else if (w_strb == '0) begin
            b_push = 1'b1;
            done   = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (mem_gnt) begin
          b_push  = 1'b1;
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  nasti_lite_b_fifo #(
    .DEPTH   (B_DEPTH),
    .entry_t (b_entry_t)
  ) u_b_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (b_push),
    .push_data (b_push_data),
    .pop       (lite_b_valid && lite_b_ready),
    .head      (b_head),
    .empty     (b_empty),
    .full      (b_full)
  );

  assign lite_b_valid = !b_empty;
  assign lite_b_id    = b_head.id[ID_WIDTH-1:0];
  assign lite_b_resp  = b_head.resp;
  assign lite_b_user  = b_head.user[USER_WIDTH-1:0];

  assign unused_ok = ^{lite_aw_prot, lite_aw_qos, lite_aw_region, lite_w_user, b_head};

endmodule

// File: tb/tb_nasti_lite_wr_slave.sv
// Bench for nasti_lite_wr_slave: directed latency/boundary cases plus random traffic
// checked by a queue-based reference model and an output-side monitor.
module tb_nasti_lite_wr_slave;

  localparam int unsigned ID_WIDTH   = 2;
  localparam int unsigned ADDR_WIDTH = 8;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned USER_WIDTH = 2;
  localparam int unsigned ADDR_SPAN  = 128;
  localparam int unsigned B_DEPTH    = 2;
  localparam int          NRAND      = 150;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  lite_aw_id;
  logic [7:0]  lite_aw_addr;
  logic [1:0]  lite_aw_user;
  logic [2:0]  lite_aw_prot;
  logic [3:0]  lite_aw_qos;
  logic [3:0]  lite_aw_region;
  logic        lite_aw_valid;
  logic        lite_aw_ready;
  logic [31:0] lite_w_data;
  logic [3:0]  lite_w_strb;
  logic [1:0]  lite_w_user;
  logic        lite_w_valid;
  logic        lite_w_ready;
  logic [1:0]  lite_b_id;
  logic [1:0]  lite_b_resp;
  logic [1:0]  lite_b_user;
  logic        lite_b_valid;
  logic        lite_b_ready;
  logic        mem_req;
  logic        mem_gnt;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  nasti_lite_wr_slave #(
    .ID_WIDTH   (ID_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .USER_WIDTH (USER_WIDTH),
    .ADDR_SPAN  (ADDR_SPAN),
    .B_DEPTH    (B_DEPTH)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .lite_aw_id     (lite_aw_id),
    .lite_aw_addr   (lite_aw_addr),
    .lite_aw_user   (lite_aw_user),
    .lite_aw_prot   (lite_aw_prot),
    .lite_aw_qos    (lite_aw_qos),
    .lite_aw_region (lite_aw_region),
    .lite_aw_valid  (lite_aw_valid),
    .lite_aw_ready  (lite_aw_ready),
    .lite_w_data    (lite_w_data),
    .lite_w_strb    (lite_w_strb),
    .lite_w_user    (lite_w_user),
    .lite_w_valid   (lite_w_valid),
    .lite_w_ready   (lite_w_ready),
    .lite_b_id      (lite_b_id),
    .lite_b_resp    (lite_b_resp),
    .lite_b_user    (lite_b_user),
    .lite_b_valid   (lite_b_valid),
    .lite_b_ready   (lite_b_ready),
    .mem_req        (mem_req),
    .mem_gnt        (mem_gnt),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb)
  );

  typedef struct { int unsigned id; int unsigned addr; int unsigned user; } aw_t;
  typedef struct { logic [31:0] data; int unsigned strb; } w_t;
  typedef struct { int unsigned id; int unsigned resp; int unsigned user; } b_exp_t;
  typedef struct { int unsigned addr; logic [31:0] data; int unsigned strb; } m_exp_t;

  aw_t    aw_q[$];
  w_t     w_q[$];
  b_exp_t exp_b[$];
  m_exp_t exp_m[$];
  aw_t    pa;
  w_t     pw;
  b_exp_t pb;
  m_exp_t pm;

  int n_cmp = 0;
  int n_bad = 0;
  bit rand_on;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: k-th AW pairs with k-th W; response and memory write follow from address and strobe.
  logic        prev_req;
  logic [7:0]  prev_addr;
  logic [31:0] prev_data;
  logic [3:0]  prev_strb;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_req = 1'b0;
    end else begin
      if (lite_aw_valid && lite_aw_ready)
        aw_q.push_back('{32'(lite_aw_id), 32'(lite_aw_addr), 32'(lite_aw_user)});
      if (lite_w_valid && lite_w_ready)
        w_q.push_back('{lite_w_data, 32'(lite_w_strb)});
      while (aw_q.size() > 0 && w_q.size() > 0) begin
        pa = aw_q.pop_front();
        pw = w_q.pop_front();
        if (pa.addr >= ADDR_SPAN) begin
          exp_b.push_back('{pa.id, 2, pa.user});
        end else begin
          exp_b.push_back('{pa.id, 0, pa.user});
          if (pw.strb != 0) exp_m.push_back('{(pa.addr / 4) * 4, pw.data, pw.strb});
        end
      end
      if (mem_req && prev_req) begin
        check("mem_addr_stable", 64'(mem_addr), 64'(prev_addr));
        check("mem_wdata_stable", 64'(mem_wdata), 64'(prev_data));
        check("mem_wstrb_stable", 64'(mem_wstrb), 64'(prev_strb));
      end
      if (mem_req && mem_gnt) begin
        if (exp_m.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL mem_unexpected: write to 0x%0h, expected no memory write", mem_addr);
        end else begin
          pm = exp_m.pop_front();
          check("mem_addr", 64'(mem_addr), 64'(pm.addr));
          check("mem_wdata", 64'(mem_wdata), 64'(pm.data));
          check("mem_wstrb", 64'(mem_wstrb), 64'(pm.strb));
        end
      end
      prev_req  = mem_req && !mem_gnt;
      prev_addr = mem_addr;
      prev_data = mem_wdata;
      prev_strb = mem_wstrb;
      if (lite_b_valid && lite_b_ready) begin
        if (exp_b.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL b_unexpected: id %0d resp %0d, expected no response", lite_b_id, lite_b_resp);
        end else begin
          pb = exp_b.pop_front();
          check("b_id", 64'(lite_b_id), 64'(pb.id));
          check("b_resp", 64'(lite_b_resp), 64'(pb.resp));
          check("b_user", 64'(lite_b_user), 64'(pb.user));
        end
      end
    end
  end

  task automatic drive_aw(input logic [1:0] id, input logic [7:0] addr, input logic [1:0] user);
    int n = 0;
    lite_aw_id     = id;
    lite_aw_addr   = addr;
    lite_aw_user   = user;
    lite_aw_prot   = 3'($urandom);
    lite_aw_qos    = 4'($urandom);
    lite_aw_region = 4'($urandom);
    lite_aw_valid  = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!lite_aw_ready && n < 300);
    if (!lite_aw_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL aw_timeout: ready %0b after %0d cycles, expected 1", lite_aw_ready, n);
    end
    next_cycle();
    lite_aw_valid = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    lite_w_data  = data;
    lite_w_strb  = strb;
    lite_w_user  = 2'($urandom);
    lite_w_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!lite_w_ready && n < 300);
    if (!lite_w_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL w_timeout: ready %0b after %0d cycles, expected 1", lite_w_ready, n);
    end
    next_cycle();
    lite_w_valid = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] id, input logic [7:0] addr, input logic [1:0] user,
                          input logic [31:0] data, input logic [3:0] strb);
    fork
      drive_aw(id, addr, user);
      drive_w(data, strb);
    join
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_b.size() != 0 || exp_m.size() != 0) && n < 500) begin
      next_cycle();
      n++;
    end
    check({name, "_b_left"}, 64'(exp_b.size()), 64'(0));
    check({name, "_m_left"}, 64'(exp_m.size()), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] d;
    rstn = 1'b0;
    lite_aw_id = '0; lite_aw_addr = '0; lite_aw_user = '0;
    lite_aw_prot = '0; lite_aw_qos = '0; lite_aw_region = '0; lite_aw_valid = 1'b0;
    lite_w_data = '0; lite_w_strb = '0; lite_w_user = '0; lite_w_valid = 1'b0;
    lite_b_ready = 1'b0; mem_gnt = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_aw_ready", 64'(lite_aw_ready), 64'(0));
    check("rst_w_ready", 64'(lite_w_ready), 64'(0));
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_b_valid", 64'(lite_b_valid), 64'(0));
    next_cycle();
    rstn = 1'b1;
    next_cycle();
    @(negedge clk);
    check("post_rst_aw_ready", 64'(lite_aw_ready), 64'(1));
    check("post_rst_w_ready", 64'(lite_w_ready), 64'(1));

    // Back-to-back AW+W with immediate grant: mem_req in cycle 2, B in cycle 3.
    next_cycle();
    lite_aw_id = 2'd1; lite_aw_addr = 8'h10; lite_aw_user = 2'd2; lite_aw_valid = 1'b1;
    lite_w_data = 32'hDEADBEEF; lite_w_strb = 4'hF; lite_w_valid = 1'b1;
    mem_gnt = 1'b1; lite_b_ready = 1'b1;
    @(negedge clk);
    check("lat_c0_aw_ready", 64'(lite_aw_ready), 64'(1));
    next_cycle();
    lite_aw_valid = 1'b0; lite_w_valid = 1'b0;
    @(negedge clk);
    check("lat_c1_mem_req", 64'(mem_req), 64'(0));
    check("lat_c1_aw_ready", 64'(lite_aw_ready), 64'(0));
    next_cycle();
    @(negedge clk);
    check("lat_c2_mem_req", 64'(mem_req), 64'(1));
    check("lat_c2_mem_addr", 64'(mem_addr), 64'h10);
    check("lat_c2_b_valid", 64'(lite_b_valid), 64'(0));
    next_cycle();
    @(negedge clk);
    check("lat_c3_b_valid", 64'(lite_b_valid), 64'(1));
    check("lat_c3_aw_ready", 64'(lite_aw_ready), 64'(1));
    check("lat_c3_w_ready", 64'(lite_w_ready), 64'(1));
    next_cycle();

    // W well ahead of an unaligned AW, grant delayed.
    mem_gnt = 1'b0;
    d = $urandom;
    lite_w_data = d; lite_w_strb = 4'h3; lite_w_valid = 1'b1;
    @(negedge clk);
    next_cycle();
    lite_w_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("early_w_ready_low", 64'(lite_w_ready), 64'(0));
      next_cycle();
    end
    lite_aw_id = 2'd2; lite_aw_addr = 8'h13; lite_aw_user = 2'd1; lite_aw_valid = 1'b1;
    @(negedge clk);
    next_cycle();
    lite_aw_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("wait_w_ready_low", 64'(lite_w_ready), 64'(0));
      next_cycle();
    end
    @(negedge clk);
    check("unaligned_mem_req", 64'(mem_req), 64'(1));
    check("unaligned_mem_addr", 64'(mem_addr), 64'h10);
    next_cycle();
    mem_gnt = 1'b1;
    @(negedge clk);
    check("gnt_w_ready_low", 64'(lite_w_ready), 64'(0));
    next_cycle();
    @(negedge clk);
    check("after_b_w_ready", 64'(lite_w_ready), 64'(1));
    check("after_b_b_valid", 64'(lite_b_valid), 64'(1));
    next_cycle();

    // Range boundary: last decoded byte, then first out-of-range address.
    do_write(2'd3, 8'h7F, 2'd0, $urandom, 4'hF);
    drain("last_in_range");
    do_write(2'd2, 8'h80, 2'd3, $urandom, 4'hF);
    repeat (4) begin
      @(negedge clk);
      check("slverr_no_mem_req", 64'(mem_req), 64'(0));
      next_cycle();
    end
    drain("slverr");

    // Zero strobe: no memory access, B two cycles after the handshake.
    lite_aw_id = 2'd1; lite_aw_addr = 8'h24; lite_aw_user = 2'd2; lite_aw_valid = 1'b1;
    lite_w_data = $urandom; lite_w_strb = 4'h0; lite_w_valid = 1'b1;
    @(negedge clk);
    next_cycle();
    lite_aw_valid = 1'b0; lite_w_valid = 1'b0;
    @(negedge clk);
    check("strb0_c1_b_valid", 64'(lite_b_valid), 64'(0));
    check("strb0_c1_mem_req", 64'(mem_req), 64'(0));
    next_cycle();
    @(negedge clk);
    check("strb0_c2_b_valid", 64'(lite_b_valid), 64'(1));
    check("strb0_c2_mem_req", 64'(mem_req), 64'(0));
    next_cycle();

    // B back-pressure: two responses fill the queue, the third write stalls with holds kept.
    lite_b_ready = 1'b0;
    do_write(2'd0, 8'h04, 2'd1, $urandom, 4'hF);
    do_write(2'd1, 8'h08, 2'd2, $urandom, 4'hC);
    do_write(2'd0, 8'h0C, 2'd3, $urandom, 4'h1);
    repeat (6) next_cycle();
    @(negedge clk);
    check("full_aw_ready", 64'(lite_aw_ready), 64'(0));
    check("full_w_ready", 64'(lite_w_ready), 64'(0));
    check("full_mem_req", 64'(mem_req), 64'(0));
    check("full_b_valid", 64'(lite_b_valid), 64'(1));
    check("full_pending", 64'(exp_b.size()), 64'(3));
    next_cycle();
    lite_b_ready = 1'b1;
    drain("full_release");

    // Random traffic with independent AW/W streams, random grant and B back-pressure.
    rand_on = 1'b1;
    fork
      begin
        fork
          for (int i = 0; i < NRAND; i++) begin
            repeat ($urandom_range(0, 2)) next_cycle();
            drive_aw(2'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom_range(128, 255))
                                                                : 8'($urandom_range(0, 127)),
                     2'($urandom));
          end
          for (int j = 0; j < NRAND; j++) begin
            repeat ($urandom_range(0, 2)) next_cycle();
            drive_w($urandom, ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom));
          end
        join
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          mem_gnt      = ($urandom_range(0, 3) != 0);
          lite_b_ready = ($urandom_range(0, 15) < 10);
          next_cycle();
        end
      end
    join
    mem_gnt = 1'b1;
    lite_b_ready = 1'b1;
    drain("random");
    check("random_aw_left", 64'(aw_q.size()), 64'(0));
    check("random_w_left", 64'(w_q.size()), 64'(0));

    // Reset while a memory request is waiting for grant.
    mem_gnt = 1'b0;
    do_write(2'd3, 8'h20, 2'd1, $urandom, 4'hF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 20);
    check("midrst_mem_req_up", 64'(mem_req), 64'(1));
    next_cycle();
    rstn = 1'b0;
    aw_q.delete(); w_q.delete(); exp_b.delete(); exp_m.delete();
    next_cycle();
    @(negedge clk);
    check("midrst_mem_req", 64'(mem_req), 64'(0));
    check("midrst_b_valid", 64'(lite_b_valid), 64'(0));
    check("midrst_aw_ready", 64'(lite_aw_ready), 64'(0));
    check("midrst_w_ready", 64'(lite_w_ready), 64'(0));
    next_cycle();
    rstn = 1'b1;
    next_cycle();
    @(negedge clk);
    check("midrst_after_aw_ready", 64'(lite_aw_ready), 64'(1));
    check("midrst_after_w_ready", 64'(lite_w_ready), 64'(1));
    check("midrst_after_mem_req", 64'(mem_req), 64'(0));
    check("midrst_after_b_valid", 64'(lite_b_valid), 64'(0));

    // Normal operation resumes after reset.
    mem_gnt = 1'b1;
    next_cycle();
    do_write(2'd2, 8'h44, 2'd2, $urandom, 4'h6);
    drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
